// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state encoding and default tick constants for key event generation
package key_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } key_state_t;

  // Defaults assume a 100 Hz tick: 1 s long press, 0.2 s repeat, 0.3 s double-click window
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;
  localparam int DEF_DBL_TICKS    = 30;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/key_event_if.sv
// rtl/key_event_if.sv - button level in, classified event pulses out
interface key_event_if;

  logic pb_debounced;
  logic press_pulse;
  logic release_pulse;
  logic single_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output pb_debounced,
    input  press_pulse, release_pulse, single_pulse, double_pulse,
           long_pulse, repeat_pulse, held
  );

  modport slave (
    input  pb_debounced,
    output press_pulse, release_pulse, single_pulse, double_pulse,
           long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - previous-level register with rise/fall strobes, reusable per button
module key_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pb,
  output logic o_rise,
  output logic o_fall
);

  logic r_pb_q;

  // Clearing to 0 makes a button held through reset register as a fresh press
  always_ff @(posedge clk) begin
    if (!rst_n) r_pb_q <= 1'b0;
    else        r_pb_q <= i_pb;
  end

  assign o_rise = i_pb & ~r_pb_q;
  assign o_fall = ~i_pb & r_pb_q;

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - classifies a debounced button into press/release/click/long/repeat pulses
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int DBL_TICKS    = DEF_DBL_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  ev
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (LONG_TICKS < 2 || LONG_TICKS > CNT_MAX ||
      REPEAT_TICKS < 2 || REPEAT_TICKS > CNT_MAX ||
      DBL_TICKS < 2 || DBL_TICKS > CNT_MAX) begin : g_bad_params
    $error("key_event_gen: tick parameter outside 2..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DBL_TICKS - 1);

  logic w_rise;
  logic w_fall;

  key_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pb   (ev.pb_debounced),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_press, r_release, r_single, r_double, r_long, r_repeat, r_held;

  // Edge tests take priority over count completion, so a release or re-press beats a due timer pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_press <= 1'b1;
            r_state <= ST_PRESS;
            r_cnt   <= '0;
            r_held  <= 1'b1;
          end
        end
        ST_PRESS, ST_PRESS2: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_state   <= (r_state == ST_PRESS) ? ST_GAP : ST_IDLE;
            r_cnt     <= '0;
            r_held    <= 1'b0;
          end else if (r_cnt == LONG_M1) begin
            r_long  <= 1'b1;
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_held    <= 1'b0;
          end else if (r_cnt == REP_M1) begin
            r_repeat <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_rise) begin
            r_press  <= 1'b1;
            r_double <= 1'b1;
            r_state  <= ST_PRESS2;
            r_cnt    <= '0;
            r_held   <= 1'b1;
          end else if (r_cnt == DBL_M1) begin
            r_single <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign ev.press_pulse   = r_press;
  assign ev.release_pulse = r_release;
  assign ev.single_pulse  = r_single;
  assign ev.double_pulse  = r_double;
  assign ev.long_pulse    = r_long;
  assign ev.repeat_pulse  = r_repeat;
  assign ev.held          = r_held;

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - randomized and directed checks of key_event_gen against a run-length event model
module tb_key_event_gen;

  localparam int LONG = 8;
  localparam int REP  = 3;
  localparam int DBL  = 4;
  localparam int MAXN = 200;

  localparam int B_PRESS  = 6;
  localparam int B_REL    = 5;
  localparam int B_SINGLE = 4;
  localparam int B_DOUBLE = 3;
  localparam int B_LONG   = 2;
  localparam int B_REPEAT = 1;
  localparam int B_HELD   = 0;

  logic clk = 1'b0;
  logic rst_n;
  key_event_if ev ();

  key_event_gen #(
    .LONG_TICKS   (LONG),
    .REPEAT_TICKS (REP),
    .DBL_TICKS    (DBL),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ev    (ev)
  );

  always #5 clk = ~clk;

  logic       pb_a   [MAXN];
  logic       rstn_a [MAXN];
  logic [6:0] exp_a  [MAXN];
  logic [6:0] obs_a  [MAXN];
  int errors = 0;
  int checks = 0;

  // Index 0 is always a reset edge, so index e is edge e after reset release
  task automatic clear_stim(input int n);
    for (int e = 0; e < n; e++) begin
      pb_a[e]   = 1'b0;
      rstn_a[e] = (e != 0);
    end
  endtask

  task automatic set_pb(input int a, input int b);
    for (int e = a; e <= b; e++) pb_a[e] = 1'b1;
  endtask

  // Model: split the level into press runs, then place each event by arithmetic on run boundaries
  task automatic build_expected(input int n);
    int s, f, p, dbl_at;
    bit is_dbl, is_long, done;
    for (int e = 0; e < n; e++) exp_a[e] = '0;
    dbl_at = -1;
    s = 0;
    while (s < n) begin
      if (!(rstn_a[s] && pb_a[s] && (s == 0 || !rstn_a[s-1] || !pb_a[s-1]))) begin
        s++;
        continue;
      end
      f = s + 1;
      while (f < n && pb_a[f] && rstn_a[f]) f++;
      is_dbl  = (s == dbl_at);
      is_long = (s + LONG < f);
      exp_a[s][B_PRESS] = 1'b1;
      if (is_dbl) exp_a[s][B_DOUBLE] = 1'b1;
      for (int e = s; e < f; e++) exp_a[e][B_HELD] = 1'b1;
      if (is_long) begin
        exp_a[s+LONG][B_LONG] = 1'b1;
        for (int t = s + LONG + REP; t < f; t += REP) exp_a[t][B_REPEAT] = 1'b1;
      end
      if (f < n && rstn_a[f]) begin
        exp_a[f][B_REL] = 1'b1;
        if (!is_long && !is_dbl) begin
          done = 1'b0;
          p = f + 1;
          while (!done && p <= f + DBL && p < n) begin
            if (!rstn_a[p]) done = 1'b1;
            else if (pb_a[p]) begin
              dbl_at = p;
              done = 1'b1;
            end
            p++;
          end
          if (!done && f + DBL < n) exp_a[f+DBL][B_SINGLE] = 1'b1;
        end
      end
      s = f;
    end
  endtask

  task automatic run_stim(input int n);
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      rst_n = rstn_a[e];
      ev.pb_debounced = pb_a[e];
      @(posedge clk);
      #1;
      obs_a[e] = {ev.press_pulse, ev.release_pulse, ev.single_pulse, ev.double_pulse,
                  ev.long_pulse, ev.repeat_pulse, ev.held};
    end
  endtask

  task automatic test_reset();
    for (int e = 0; e < 8; e++) begin
      pb_a[e]   = 1'($urandom_range(0, 1));
      rstn_a[e] = 1'b0;
    end
    run_stim(8);
    for (int e = 0; e < 8; e++) begin
      checks++;
      if (obs_a[e] !== 7'b0) begin
        errors++;
        $display("FAIL reset edge %0d: got %b want %b", e, obs_a[e], 7'b0);
      end
    end
  endtask

  task automatic test_short_click();
    clear_stim(20);
    set_pb(5, 7);
    build_expected(20);
    run_stim(20);
    for (int e = 0; e < 20; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL short_click edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[5][B_PRESS], obs_a[8][B_REL], obs_a[12][B_SINGLE], obs_a[7][B_HELD], obs_a[8][B_HELD]} !== 5'b11110) begin
      errors++;
      $display("FAIL short_click_spot: got %b want 11110",
               {obs_a[5][B_PRESS], obs_a[8][B_REL], obs_a[12][B_SINGLE], obs_a[7][B_HELD], obs_a[8][B_HELD]});
    end
  endtask

  task automatic test_long_repeat();
    clear_stim(40);
    set_pb(5, 24);
    build_expected(40);
    run_stim(40);
    for (int e = 0; e < 40; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL long_repeat edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[13][B_LONG], obs_a[16][B_REPEAT], obs_a[22][B_REPEAT], obs_a[25][B_REL], obs_a[25][B_REPEAT]} !== 5'b11110) begin
      errors++;
      $display("FAIL long_repeat_spot: got %b want 11110",
               {obs_a[13][B_LONG], obs_a[16][B_REPEAT], obs_a[22][B_REPEAT], obs_a[25][B_REL], obs_a[25][B_REPEAT]});
    end
  endtask

  task automatic test_double_click();
    clear_stim(25);
    set_pb(5, 6);
    set_pb(9, 10);
    build_expected(25);
    run_stim(25);
    for (int e = 0; e < 25; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL double_click edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[9][B_PRESS], obs_a[9][B_DOUBLE], obs_a[11][B_REL], obs_a[15][B_SINGLE]} !== 4'b1110) begin
      errors++;
      $display("FAIL double_click_spot: got %b want 1110",
               {obs_a[9][B_PRESS], obs_a[9][B_DOUBLE], obs_a[11][B_REL], obs_a[15][B_SINGLE]});
    end
  endtask

  task automatic test_boundaries();
    clear_stim(25);
    set_pb(5, 6);
    set_pb(11, 12);
    build_expected(25);
    run_stim(25);
    for (int e = 0; e < 25; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL boundary_double edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[11][B_DOUBLE], obs_a[11][B_SINGLE]} !== 2'b10) begin
      errors++;
      $display("FAIL boundary_double_spot: got %b want 10", {obs_a[11][B_DOUBLE], obs_a[11][B_SINGLE]});
    end
    clear_stim(25);
    set_pb(5, 12);
    build_expected(25);
    run_stim(25);
    for (int e = 0; e < 25; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL boundary_long edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[13][B_REL], obs_a[13][B_LONG], obs_a[17][B_SINGLE]} !== 3'b101) begin
      errors++;
      $display("FAIL boundary_long_spot: got %b want 101", {obs_a[13][B_REL], obs_a[13][B_LONG], obs_a[17][B_SINGLE]});
    end
  endtask

  task automatic test_reset_mid_hold();
    clear_stim(40);
    set_pb(5, 24);
    rstn_a[15] = 1'b0;
    build_expected(40);
    run_stim(40);
    for (int e = 0; e < 40; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL reset_mid_hold edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[15], obs_a[16][B_PRESS]} !== 8'b0000000_1) begin
      errors++;
      $display("FAIL reset_mid_hold_spot: got %b want 00000001", {obs_a[15], obs_a[16][B_PRESS]});
    end
  endtask

  task automatic test_reset_held();
    clear_stim(20);
    for (int e = 0; e < 20; e++) begin
      pb_a[e]   = 1'b1;
      rstn_a[e] = (e >= 4);
    end
    build_expected(20);
    run_stim(20);
    for (int e = 0; e < 20; e++) begin
      checks++;
      if (obs_a[e] !== exp_a[e]) begin
        errors++;
        $display("FAIL reset_held edge %0d: got %b want %b", e, obs_a[e], exp_a[e]);
      end
    end
    checks++;
    if ({obs_a[3], obs_a[4][B_PRESS]} !== 8'b0000000_1) begin
      errors++;
      $display("FAIL reset_held_spot: got %b want 00000001", {obs_a[3], obs_a[4][B_PRESS]});
    end
  endtask

  task automatic test_random();
    int n, e, len;
    logic lvl;
    for (int it = 0; it < 20; it++) begin
      n = 150;
      lvl = 1'b0;
      e = 0;
      while (e < n) begin
        len = $urandom_range(1, 12);
        for (int k = 0; k < len && e < n; k++) begin
          pb_a[e]   = lvl;
          rstn_a[e] = (e != 0) && ($urandom_range(0, 79) != 0);
          e++;
        end
        lvl = ~lvl;
      end
      build_expected(n);
      run_stim(n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_a[i] !== exp_a[i]) begin
          errors++;
          $display("FAIL random it %0d edge %0d: got %b want %b", it, i, obs_a[i], exp_a[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ev.pb_debounced = 1'b0;
    test_reset();
    test_short_click();
    test_long_repeat();
    test_double_click();
    test_boundaries();
    test_reset_mid_hold();
    test_reset_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Downstream consumer of the push-button debouncer's level output (`pb_debounced`, 1 = pressed).
- Classifies presses into one-cycle event pulses: press, release, single click, double click, long press and auto-repeat while held.
- Runs on the same ~100 Hz clock as the debouncer, so all timing parameters are in clock ticks.
- Its pulses drive the application FSMs (mode select, counters) directly.

Parameters:
- LONG_TICKS, 100, ticks held before long_pulse (1 s at 100 Hz); range 2..2^CNT_W-1
- REPEAT_TICKS, 20, ticks between repeat_pulse while in long hold; range 2..2^CNT_W-1
- DBL_TICKS, 30, max ticks from release to re-press that counts as a double click; range 2..2^CNT_W-1
- CNT_W, 8, tick counter width

Ports:
- clk  input  1  system clock (~100 Hz tick domain)
- rst_n  input  1  reset; synchronous, active-low
- pb_debounced  input  1  debounced button level, 1 = pressed
- press_pulse  output  1  one-cycle pulse on each press
- release_pulse  output  1  one-cycle pulse on each release
- single_pulse  output  1  one-cycle pulse: short click confirmed, no second press in window
- double_pulse  output  1  one-cycle pulse on the second press of a double click
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_TICKS
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TICKS while in long hold
- held  output  1  level; 1 while the FSM is in a pressed state

Behaviour:
- Clock and reset
  - One clock.
  - Reset is synchronous, active-low: rst_n sampled low at a rising clk edge clears everything.
- Reset values:
  - state = IDLE, cnt = 0, pb_q = 0.
  - All outputs 0, including held.
- Inputs
  - pb_q holds the previous-cycle pb_debounced.
  - rise = pb & ~pb_q; fall = ~pb & pb_q.
- Outputs and latency
  - All outputs are registered.
  - Each pulse is high for exactly one cycle, asserted at the same edge at which the FSM samples the causing condition (edge N → visible N..N+1).
  - held is registered from the next state.
- States: IDLE, PRESS, HOLD, GAP, PRESS2 (3-bit encoding).
- IDLE
  - On rise: press_pulse, → PRESS, cnt = 0.
- PRESS
  - If pb = 0: release_pulse, → GAP, cnt = 0.
  - Else if cnt == LONG_TICKS-1: long_pulse, → HOLD, cnt = 0.
  - Else cnt++.
  - Result: long_pulse arrives at press edge + LONG_TICKS.
- HOLD
  - If pb = 0: release_pulse, → IDLE. No single or double follows a long press.
  - Else if cnt == REPEAT_TICKS-1: repeat_pulse, cnt = 0.
  - Else cnt++.
  - Result: repeats at long edge + k·REPEAT_TICKS.
- GAP
  - If pb = 1: press_pulse and double_pulse together, → PRESS2, cnt = 0.
  - Else if cnt == DBL_TICKS-1: single_pulse, → IDLE.
  - Else cnt++.
  - Result: single_pulse at release edge + DBL_TICKS.
- PRESS2
  - Same as PRESS, except pb = 0 → release_pulse, → IDLE. No triple click.
  - Long-hold and repeat still apply: → HOLD.
- Simultaneous events
  - Release on the edge where the long count completes: release wins; no long_pulse.
  - Re-press on the edge where the GAP count completes: double wins; no single_pulse.
  - Release on the edge where a repeat is due: release wins; no repeat_pulse.
- Counter: cnt never exceeds max(parameter)-1. No wrap is possible; all compares use the CNT_W width.
- Reset mid-operation
  - Any state → IDLE, with no release_pulse or single_pulse.
  - pb_q clears to 0, so a button still held when reset deasserts produces press_pulse on the first edge after reset.
- Out-of-range parameters are a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package key_event_pkg holds:
  - state encoding constants (ST_IDLE, ST_PRESS, ST_HOLD, ST_GAP, ST_PRESS2)
  - default tick constants for 100 Hz (1 s long, 0.2 s repeat, 0.3 s double).
- One sub-module, key_edge_det: pb_q register plus rise/fall outputs, with the same synchronous reset. It is reusable for the other buttons.

Test Plan:
Bench parameters: LONG_TICKS = 8, REPEAT_TICKS = 3, DBL_TICKS = 4. Edges numbered after reset release.
- Short click: pb = 1 sampled edges 5–7, 0 from edge 8.
  - press_pulse @5, release_pulse @8, single_pulse @12.
  - held = 1 for cycles 5–7.
  - No other pulses.
- Long + repeat: pb = 1 at edges 5–24, 0 at 25.
  - press @5, long @13, repeat @16, @19, @22, release @25.
  - No single_pulse; release beats the repeat due @25.
- Double click: pb = 1 at 5–6, 0 at 7–8, 1 at 9–10, 0 from 11.
  - press @5, release @7, press + double @9, release @11.
  - No single_pulse afterwards.
- Boundaries:
  - Release @7 with re-press exactly @11: double_pulse @11, no single.
  - Separately, press @5 with fall sampled exactly @13: release @13, no long_pulse, single_pulse @17.
- Reset mid-HOLD: run the long scenario, drive rst_n low sampled @15 with pb held.
  - All outputs 0 @15, state IDLE, no release_pulse.
  - Release reset @16 with pb = 1: press_pulse @16.
- Reset with pb = 1 throughout:
  - No pulses while rst_n = 0.
  - First edge with rst_n = 1 yields press_pulse.
